// File: rtl/shape_vertex_streamer.sv
// rtl/shape_vertex_streamer.sv - streams the vertices of one shape instruction per handshake
module shape_vertex_streamer #(
    parameter int width  = 4,
    parameter int height = 3,
    parameter int cnt_w  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        shape,
    input  logic [width-1:0]  x1,
    input  logic [width-1:0]  x2,
    input  logic [width-1:0]  x3,
    input  logic [height-1:0] y1,
    input  logic [height-1:0] y2,
    input  logic [height-1:0] y3,
    output logic              vert_valid,
    input  logic              vert_ready,
    output logic [width-1:0]  vert_x,
    output logic [height-1:0] vert_y,
    output logic [1:0]        vert_idx,
    output logic              vert_last,
    output logic              vert_oob,
    output logic              busy,
    output logic [cnt_w-1:0]  done_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t state;

    logic [1:0]        shape_r;
    logic [width-1:0]  px [0:2];
    logic [height-1:0] py [0:2];

    logic [width-1:0]  vx   [0:3];
    logic [height-1:0] vy   [0:3];
    logic              voob [0:3];
    logic [1:0]        last_idx;
    logic [1:0]        idx;
    logic [1:0]        next_idx;

    logic [width-1:0]  tx   [0:3];
    logic [height-1:0] ty   [0:3];
    logic              toob [0:3];
    logic [1:0]        tlast;

    // Two extra bits hold both the carry of x2+x3 and the sign of the subtraction.
    logic signed [width+1:0]  sum_x;
    logic signed [height+1:0] sum_y;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign next_idx = idx + 2'd1;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            tx[i]   = '0;
            ty[i]   = '0;
            toob[i] = 1'b0;
        end
        tlast = 2'd2;
        sum_x = $signed({2'b00, px[1]}) + $signed({2'b00, px[2]}) - $signed({2'b00, px[0]});
        sum_y = $signed({2'b00, py[1]}) + $signed({2'b00, py[2]}) - $signed({2'b00, py[0]});
        case (shape_r)
            2'd0: begin
                for (int i = 0; i < 3; i++) begin
                    tx[i] = px[i];
                    ty[i] = py[i];
                end
                tlast = 2'd2;
            end
            2'd1: begin
                for (int i = 0; i < 3; i++) begin
                    tx[i] = px[i];
                    ty[i] = py[i];
                end
                tx[3]   = sum_x[width-1:0];
                ty[3]   = sum_y[height-1:0];
                // Any set bit above the coordinate field means negative or above max.
                toob[3] = (|sum_x[width+1:width]) | (|sum_y[height+1:height]);
                tlast   = 2'd3;
            end
            2'd2: begin
                tx[0] = px[0]; ty[0] = py[0];
                tx[1] = px[1]; ty[1] = py[0];
                tx[2] = px[1]; ty[2] = py[1];
                tx[3] = px[0]; ty[3] = py[1];
                tlast = 2'd3;
            end
            default: begin
                tx[0] = px[0]; ty[0] = py[0];
                tx[1] = px[1]; ty[1] = py[1];
                tlast = 2'd1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shape_r    <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                px[i] <= '0;
                py[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                vx[i]   <= '0;
                vy[i]   <= '0;
                voob[i] <= 1'b0;
            end
            last_idx   <= 2'd0;
            idx        <= 2'd0;
            vert_valid <= 1'b0;
            vert_x     <= '0;
            vert_y     <= '0;
            vert_idx   <= 2'd0;
            vert_last  <= 1'b0;
            vert_oob   <= 1'b0;
            done_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shape_r <= shape;
                        px[0]   <= x1;
                        px[1]   <= x2;
                        px[2]   <= x3;
                        py[0]   <= y1;
                        py[1]   <= y2;
                        py[2]   <= y3;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    for (int i = 0; i < 4; i++) begin
                        vx[i]   <= tx[i];
                        vy[i]   <= ty[i];
                        voob[i] <= toob[i];
                    end
                    last_idx   <= tlast;
                    idx        <= 2'd0;
                    // V0 goes straight to the output registers so EMIT starts presenting at once.
                    vert_x     <= tx[0];
                    vert_y     <= ty[0];
                    vert_oob   <= toob[0];
                    vert_idx   <= 2'd0;
                    vert_last  <= (tlast == 2'd0);
                    vert_valid <= 1'b1;
                    state      <= EMIT;
                end
                EMIT: begin
                    if (vert_ready) begin
                        if (idx == last_idx) begin
                            vert_valid <= 1'b0;
                            vert_last  <= 1'b0;
                            done_cnt   <= done_cnt + 1'b1;
                            state      <= IDLE;
                        end else begin
                            idx       <= next_idx;
                            vert_x    <= vx[next_idx];
                            vert_y    <= vy[next_idx];
                            vert_oob  <= voob[next_idx];
                            vert_idx  <= next_idx;
                            vert_last <= (next_idx == last_idx);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shape_vertex_streamer.sv
// tb/tb_shape_vertex_streamer.sv - directed self-checking bench for shape_vertex_streamer
module tb_shape_vertex_streamer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // main instance: width 4, height 3, cnt_w 8
    logic       m_in_valid = 0, m_in_ready, m_vert_valid, m_vert_ready = 1;
    logic [1:0] m_shape = 0, m_vert_idx;
    logic [3:0] m_x1 = 0, m_x2 = 0, m_x3 = 0, m_vert_x;
    logic [2:0] m_y1 = 0, m_y2 = 0, m_y3 = 0, m_vert_y;
    logic       m_vert_last, m_vert_oob, m_busy;
    logic [7:0] m_done_cnt;

    shape_vertex_streamer #(.width(4), .height(3), .cnt_w(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .shape(m_shape), .x1(m_x1), .x2(m_x2), .x3(m_x3), .y1(m_y1), .y2(m_y2), .y3(m_y3),
        .vert_valid(m_vert_valid), .vert_ready(m_vert_ready), .vert_x(m_vert_x), .vert_y(m_vert_y),
        .vert_idx(m_vert_idx), .vert_last(m_vert_last), .vert_oob(m_vert_oob),
        .busy(m_busy), .done_cnt(m_done_cnt)
    );

    // width 5, height 5 instance
    logic       f_in_valid = 0, f_in_ready, f_vert_valid, f_vert_ready = 1;
    logic [1:0] f_shape = 0, f_vert_idx;
    logic [4:0] f_x1 = 0, f_x2 = 0, f_x3 = 0, f_vert_x;
    logic [4:0] f_y1 = 0, f_y2 = 0, f_y3 = 0, f_vert_y;
    logic       f_vert_last, f_vert_oob, f_busy;
    logic [7:0] f_done_cnt;

    shape_vertex_streamer #(.width(5), .height(5), .cnt_w(8)) dut_w5 (
        .clk(clk), .rst_n(rst_n), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .shape(f_shape), .x1(f_x1), .x2(f_x2), .x3(f_x3), .y1(f_y1), .y2(f_y2), .y3(f_y3),
        .vert_valid(f_vert_valid), .vert_ready(f_vert_ready), .vert_x(f_vert_x), .vert_y(f_vert_y),
        .vert_idx(f_vert_idx), .vert_last(f_vert_last), .vert_oob(f_vert_oob),
        .busy(f_busy), .done_cnt(f_done_cnt)
    );

    // cnt_w 2 instance
    logic       c_in_valid = 0, c_in_ready, c_vert_valid, c_vert_ready = 1;
    logic [1:0] c_shape = 0, c_vert_idx;
    logic [3:0] c_x1 = 0, c_x2 = 0, c_x3 = 0, c_vert_x;
    logic [2:0] c_y1 = 0, c_y2 = 0, c_y3 = 0, c_vert_y;
    logic       c_vert_last, c_vert_oob, c_busy;
    logic [1:0] c_done_cnt;

    shape_vertex_streamer #(.width(4), .height(3), .cnt_w(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .shape(c_shape), .x1(c_x1), .x2(c_x2), .x3(c_x3), .y1(c_y1), .y2(c_y2), .y3(c_y3),
        .vert_valid(c_vert_valid), .vert_ready(c_vert_ready), .vert_x(c_vert_x), .vert_y(c_vert_y),
        .vert_idx(c_vert_idx), .vert_last(c_vert_last), .vert_oob(c_vert_oob),
        .busy(c_busy), .done_cnt(c_done_cnt)
    );

    // captured main-instance vertices, packed {x, y, idx, last, oob}
    logic [10:0] cap_v [8];
    int cap_n, first_valid_k, ready_k, stall_cycles, stall_changes;

    task automatic run_main(input logic [1:0] sh, input logic [3:0] ax1, input logic [2:0] ay1,
                            input logic [3:0] ax2, input logic [2:0] ay2,
                            input logic [3:0] ax3, input logic [2:0] ay3,
                            input int stall_idx, input int stall_len);
        logic [10:0] snap;
        int left;
        bit done_seen;
        for (int i = 0; i < 8; i++) cap_v[i] = '0;
        cap_n = 0; first_valid_k = -1; ready_k = -1; stall_cycles = 0; stall_changes = 0;
        done_seen = 0; left = stall_len; snap = '0;
        @(negedge clk);
        m_shape = sh; m_x1 = ax1; m_y1 = ay1; m_x2 = ax2; m_y2 = ay2; m_x3 = ax3; m_y3 = ay3;
        m_in_valid = 1;
        for (int b = 0; b < 20 && !m_in_ready; b++) @(negedge clk);
        @(negedge clk);
        m_in_valid = 0;
        for (int k = 0; k < 40; k++) begin
            if (m_vert_valid && first_valid_k < 0) first_valid_k = k;
            if (done_seen && m_in_ready) begin
                ready_k = k;
                break;
            end
            if (m_vert_valid && int'(m_vert_idx) == stall_idx && left > 0) begin
                if (left == stall_len)
                    snap = {m_vert_x, m_vert_y, m_vert_idx, m_vert_last, m_vert_oob};
                else if ({m_vert_x, m_vert_y, m_vert_idx, m_vert_last, m_vert_oob} !== snap)
                    stall_changes++;
                m_vert_ready = 0;
                left--;
                stall_cycles++;
            end else begin
                m_vert_ready = 1;
            end
            if (m_vert_valid && m_vert_ready) begin
                if (cap_n < 8) cap_v[cap_n] = {m_vert_x, m_vert_y, m_vert_idx, m_vert_last, m_vert_oob};
                cap_n++;
                if (m_vert_last) done_seen = 1;
            end
            @(negedge clk);
        end
        m_vert_ready = 1;
    endtask

    task automatic test_reset;
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if ({m_in_ready, m_vert_valid, m_busy} !== 3'b100) begin
            n_err++; $display("FAIL reset_ctrl got %b want 100", {m_in_ready, m_vert_valid, m_busy});
        end
        n_vec++;
        if ({m_vert_x, m_vert_y, m_vert_idx, m_vert_last, m_vert_oob, m_done_cnt} !== 19'd0) begin
            n_err++; $display("FAIL reset_outputs got %h want 0",
                              {m_vert_x, m_vert_y, m_vert_idx, m_vert_last, m_vert_oob, m_done_cnt});
        end
        rst_n = 1;
        @(negedge clk);
        n_vec++;
        if ({c_done_cnt, c_in_ready, f_done_cnt, f_in_ready} !== 12'b00_1_00000000_1) begin
            n_err++; $display("FAIL reset_others got %b", {c_done_cnt, c_in_ready, f_done_cnt, f_in_ready});
        end
    endtask

    task automatic test_square;
        logic [10:0] exp_v [4] = '{{4'd0, 3'd0, 2'd0, 1'b0, 1'b0}, {4'd1, 3'd0, 2'd1, 1'b0, 1'b0},
                                   {4'd0, 3'd1, 2'd2, 1'b0, 1'b0}, {4'd1, 3'd1, 2'd3, 1'b1, 1'b0}};
        run_main(2'd1, 4'd0, 3'd0, 4'd1, 3'd0, 4'd0, 3'd1, -1, 0);
        n_vec++;
        if (cap_n !== 4) begin n_err++; $display("FAIL square_count got %0d want 4", cap_n); end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (cap_v[i] !== exp_v[i]) begin
                n_err++; $display("FAIL square_v%0d got %b want %b", i, cap_v[i], exp_v[i]);
            end
        end
        n_vec++;
        if (m_done_cnt !== 8'd1) begin n_err++; $display("FAIL square_done got %0d want 1", m_done_cnt); end
        n_vec++;
        if (first_valid_k !== 1) begin
            n_err++; $display("FAIL square_latency got %0d want 1", first_valid_k);
        end
        // in_ready seen high 5 edges after the accept edge -> next accept 6 clocks later
        n_vec++;
        if (ready_k !== 5) begin n_err++; $display("FAIL square_period got %0d want 5", ready_k); end
    endtask

    task automatic test_triangle;
        logic [10:0] exp_v [3] = '{{4'd0, 3'd0, 2'd0, 1'b0, 1'b0}, {4'd1, 3'd0, 2'd1, 1'b0, 1'b0},
                                   {4'd0, 3'd1, 2'd2, 1'b1, 1'b0}};
        run_main(2'd0, 4'd0, 3'd0, 4'd1, 3'd0, 4'd0, 3'd1, -1, 0);
        n_vec++;
        if (cap_n !== 3) begin n_err++; $display("FAIL tri_count got %0d want 3", cap_n); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (cap_v[i] !== exp_v[i]) begin
                n_err++; $display("FAIL tri_v%0d got %b want %b", i, cap_v[i], exp_v[i]);
            end
        end
        n_vec++;
        if (ready_k !== 4) begin n_err++; $display("FAIL tri_period got %0d want 4", ready_k); end
    endtask

    task automatic test_triangle_w5;
        logic [4:0] ex [3] = '{5'd16, 5'd10, 5'd4};
        logic [4:0] ey [3] = '{5'd16, 5'd2, 5'd2};
        logic [11:0] got [3];
        int n;
        n = 0;
        for (int i = 0; i < 3; i++) got[i] = '0;
        @(negedge clk);
        f_shape = 0; f_x1 = 16; f_y1 = 16; f_x2 = 10; f_y2 = 2; f_x3 = 4; f_y3 = 2;
        f_in_valid = 1; f_vert_ready = 1;
        for (int b = 0; b < 20 && !f_in_ready; b++) @(negedge clk);
        @(negedge clk);
        f_in_valid = 0;
        for (int k = 0; k < 20; k++) begin
            if (f_vert_valid && f_vert_ready) begin
                if (n < 3) got[n] = {f_vert_x, f_vert_y, f_vert_last, f_vert_oob};
                n++;
                if (f_vert_last) break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (n !== 3) begin n_err++; $display("FAIL w5_count got %0d want 3", n); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (got[i] !== {ex[i], ey[i], i == 2, 1'b0}) begin
                n_err++; $display("FAIL w5_v%0d got %b want %b", i, got[i], {ex[i], ey[i], i == 2, 1'b0});
            end
        end
        n_vec++;
        if ({f_done_cnt, f_busy} !== {8'd1, 1'b0}) begin
            n_err++; $display("FAIL w5_done got %0d/%b want 1/0", f_done_cnt, f_busy);
        end
    endtask

    task automatic test_overflow;
        logic [10:0] exp_a [4] = '{{4'd0, 3'd0, 2'd0, 1'b0, 1'b0}, {4'd15, 3'd0, 2'd1, 1'b0, 1'b0},
                                   {4'd15, 3'd7, 2'd2, 1'b0, 1'b0}, {4'd14, 3'd7, 2'd3, 1'b1, 1'b1}};
        logic [10:0] exp_b [4] = '{{4'd15, 3'd7, 2'd0, 1'b0, 1'b0}, {4'd0, 3'd0, 2'd1, 1'b0, 1'b0},
                                   {4'd0, 3'd0, 2'd2, 1'b0, 1'b0}, {4'd1, 3'd1, 2'd3, 1'b1, 1'b1}};
        run_main(2'd1, 4'd0, 3'd0, 4'd15, 3'd0, 4'd15, 3'd7, -1, 0);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (cap_v[i] !== exp_a[i]) begin
                n_err++; $display("FAIL ovf_hi_v%0d got %b want %b", i, cap_v[i], exp_a[i]);
            end
        end
        run_main(2'd1, 4'd15, 3'd7, 4'd0, 3'd0, 4'd0, 3'd0, -1, 0);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (cap_v[i] !== exp_b[i]) begin
                n_err++; $display("FAIL ovf_neg_v%0d got %b want %b", i, cap_v[i], exp_b[i]);
            end
        end
        n_vec++;
        if (m_done_cnt !== 8'd4) begin n_err++; $display("FAIL ovf_done got %0d want 4", m_done_cnt); end
    endtask

    task automatic test_rect_backpressure;
        logic [10:0] exp_v [4] = '{{4'd2, 3'd1, 2'd0, 1'b0, 1'b0}, {4'd5, 3'd1, 2'd1, 1'b0, 1'b0},
                                   {4'd5, 3'd4, 2'd2, 1'b0, 1'b0}, {4'd2, 3'd4, 2'd3, 1'b1, 1'b0}};
        run_main(2'd2, 4'd2, 3'd1, 4'd5, 3'd4, 4'd9, 3'd6, 1, 3);
        n_vec++;
        if (cap_n !== 4) begin n_err++; $display("FAIL rect_count got %0d want 4", cap_n); end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (cap_v[i] !== exp_v[i]) begin
                n_err++; $display("FAIL rect_v%0d got %b want %b", i, cap_v[i], exp_v[i]);
            end
        end
        n_vec++;
        if ({stall_cycles, stall_changes} !== {32'd3, 32'd0}) begin
            n_err++; $display("FAIL rect_stall got %0d cycles %0d changes want 3 cycles 0 changes",
                              stall_cycles, stall_changes);
        end
        n_vec++;
        if (ready_k !== 8) begin n_err++; $display("FAIL rect_period got %0d want 8", ready_k); end
    endtask

    task automatic test_line;
        logic [10:0] exp_v [2] = '{{4'd3, 3'd2, 2'd0, 1'b0, 1'b0}, {4'd12, 3'd5, 2'd1, 1'b1, 1'b0}};
        run_main(2'd3, 4'd3, 3'd2, 4'd12, 3'd5, 4'd7, 3'd7, -1, 0);
        n_vec++;
        if (cap_n !== 2) begin n_err++; $display("FAIL line_count got %0d want 2", cap_n); end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (cap_v[i] !== exp_v[i]) begin
                n_err++; $display("FAIL line_v%0d got %b want %b", i, cap_v[i], exp_v[i]);
            end
        end
        n_vec++;
        if (m_done_cnt !== 8'd6) begin n_err++; $display("FAIL line_done got %0d want 6", m_done_cnt); end
    endtask

    task automatic test_reset_midop;
        int seen;
        @(negedge clk);
        m_shape = 1; m_x1 = 0; m_y1 = 0; m_x2 = 1; m_y2 = 0; m_x3 = 0; m_y3 = 1;
        m_in_valid = 1; m_vert_ready = 1;
        for (int b = 0; b < 20 && !m_in_ready; b++) @(negedge clk);
        @(negedge clk);
        m_in_valid = 0;
        for (int k = 0; k < 20 && !(m_vert_valid && m_vert_idx == 2'd2); k++) @(negedge clk);
        n_vec++;
        if ({m_vert_valid, m_vert_idx} !== 3'b110) begin
            n_err++; $display("FAIL midop_reach got %b want 110", {m_vert_valid, m_vert_idx});
        end
        #2 rst_n = 0;
        #1;
        n_vec++;
        if ({m_vert_valid, m_in_ready, m_busy, m_done_cnt} !== {3'b010, 8'd0}) begin
            n_err++; $display("FAIL midop_async got %b want 01000000000",
                              {m_vert_valid, m_in_ready, m_busy, m_done_cnt});
        end
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (m_vert_valid) seen++;
        end
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (m_vert_valid) seen++;
        end
        n_vec++;
        if (seen !== 0) begin n_err++; $display("FAIL midop_quiet got %0d valid cycles want 0", seen); end
        run_main(2'd0, 4'd7, 3'd3, 4'd8, 3'd4, 4'd9, 3'd5, -1, 0);
        n_vec++;
        if ({cap_v[0], cap_v[2]} !== {4'd7, 3'd3, 2'd0, 1'b0, 1'b0, 4'd9, 3'd5, 2'd2, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL midop_restart got %b %b", cap_v[0], cap_v[2]);
        end
        n_vec++;
        if (m_done_cnt !== 8'd1) begin n_err++; $display("FAIL midop_done got %0d want 1", m_done_cnt); end
    endtask

    task automatic test_counter_wrap;
        logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [1:0] seq [8];
        logic [1:0] prev;
        int acc, nchg, blocked, nverts;
        for (int i = 0; i < 8; i++) seq[i] = '0;
        acc = 0; nchg = 0; blocked = 0; nverts = 0;
        @(negedge clk);
        c_shape = 0; c_x1 = 1; c_y1 = 1; c_x2 = 2; c_y2 = 2; c_x3 = 3; c_y3 = 1;
        c_vert_ready = 1; c_in_valid = 1;
        prev = c_done_cnt;
        for (int k = 0; k < 60; k++) begin
            if (c_done_cnt !== prev) begin
                if (nchg < 8) seq[nchg] = c_done_cnt;
                nchg++;
                prev = c_done_cnt;
            end
            if (c_busy && c_in_ready) blocked++;
            if (c_vert_valid && c_vert_ready) nverts++;
            if (acc == 5) c_in_valid = 0;
            else if (c_in_valid && c_in_ready) acc++;
            if (nchg >= 5 && !c_busy) break;
            @(negedge clk);
        end
        c_in_valid = 0;
        n_vec++;
        if (nchg !== 5) begin n_err++; $display("FAIL wrap_changes got %0d want 5", nchg); end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (seq[i] !== exp_seq[i]) begin
                n_err++; $display("FAIL wrap_seq%0d got %0d want %0d", i, seq[i], exp_seq[i]);
            end
        end
        n_vec++;
        if ({blocked, nverts, acc} !== {32'd0, 32'd15, 32'd5}) begin
            n_err++; $display("FAIL wrap_block got blocked %0d verts %0d accepts %0d want 0 15 5",
                              blocked, nverts, acc);
        end
    endtask

    initial begin
        test_reset;
        test_square;
        test_triangle;
        test_triangle_w5;
        test_overflow;
        test_rect_backpressure;
        test_line;
        test_reset_midop;
        test_counter_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
